dcache_line_xfer_queue: RTL and testbench

- Sits directly downstream of the data-cache miss/eviction logic and upstream of the 256-bit bus interface.
- Accepts 512-bit line transfers: a load is a line fill and a dump is a dirty-line writeback. Each transfer is queued in an entry shaped after dcache_req_queue_t.
- Each transfer is split into two 256-bit bus transactions. Out-of-order responses are matched by tid and reassembled.
- Completed lines are returned to the cache strictly in allocation order.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/dcache_line_xfer_queue.sv | 170 +++++++++++++++++
 tb/tb_dcache_line_xfer_queue.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared data-cache types: line transfer queue entry and bus transaction tag.
package cache_pkg;

  typedef logic [31:0] address_t;
  typedef logic [4:0]  rob_ndx_t;

  localparam int DCACHE_XFER_HALVES = 2;

  // Widest tag for a 16-entry queue; narrower queues use the low bits.
  typedef struct packed {
    logic [3:0] idx;
    logic       half;
  } dcache_xfer_tid_t;

  typedef struct packed {
    logic                          v;
    logic [DCACHE_XFER_HALVES-1:0] out;
    logic [DCACHE_XFER_HALVES-1:0] done;
    logic [DCACHE_XFER_HALVES-1:0] loaded;
    logic                          err;
    logic                          load;
    logic                          dump;
    logic                          wa;
    address_t                      adr;
    cache_pkg::rob_ndx_t           rndx;
  } dcache_req_queue_t;

  function automatic address_t line_adr(input address_t a);
    return {a[$bits(address_t)-1:6], 6'b0};
  endfunction

endpackage

// File: rtl/dcache_line_xfer_queue.sv
// Queues 512-bit line fills/writebacks, issues them as two 256-bit bus
// transactions, reassembles out-of-order responses and completes in order.
module dcache_line_xfer_queue
  import cache_pkg::*;
#(
  parameter int NENTRIES = 4,
  parameter int TIDW     = $clog2(NENTRIES) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_load_i,
  input  logic                   req_dump_i,
  input  logic                   req_wa_i,
  input  logic [$bits(address_t)-1:0] req_adr_i,
  input  logic [511:0]           req_dat_i,
  input  logic [$bits(rob_ndx_t)-1:0] req_rndx_i,
  output logic                   bus_req_valid_o,
  input  logic                   bus_req_ready_i,
  output logic                   bus_req_we_o,
  output logic [$bits(address_t)-1:0] bus_req_adr_o,
  output logic [255:0]           bus_req_dat_o,
  output logic [31:0]            bus_req_sel_o,
  output logic [TIDW-1:0]        bus_req_tid_o,
  input  logic                   bus_resp_valid_i,
  input  logic [TIDW-1:0]        bus_resp_tid_i,
  input  logic [255:0]           bus_resp_dat_i,
  input  logic                   bus_resp_err_i,
  output logic                   cmp_valid_o,
  input  logic                   cmp_ready_i,
  output logic                   cmp_is_load_o,
  output logic                   cmp_wa_o,
  output logic                   cmp_err_o,
  output logic [$bits(address_t)-1:0] cmp_adr_o,
  output logic [511:0]           cmp_dat_o,
  output logic [$bits(rob_ndx_t)-1:0] cmp_rndx_o,
  output logic                   stray_o
);

  localparam int IW = $clog2(NENTRIES);
  typedef logic [IW-1:0] ptr_t;

  dcache_req_queue_t ent_q [NENTRIES];
  dcache_req_queue_t ent_d [NENTRIES];
  logic [511:0]      dat_q [NENTRIES];
  logic [511:0]      dat_d [NENTRIES];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t iptr_q, iptr_d;
  logic ihalf_q, ihalf_d;
  logic stray_q, stray_d;

  logic hazard;
  logic req_fire;
  logic bus_fire;
  logic cmp_fire;
  logic resp_match;
  ptr_t ridx;
  logic rhalf;

  // A second transfer to a line already in flight would race the first.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (ent_q[i].v && (ent_q[i].adr[$bits(address_t)-1:6] == req_adr_i[$bits(address_t)-1:6]))
        hazard = 1'b1;
    end
  end

  assign req_ready_o     = !ent_q[tail_q].v && !hazard;
  assign req_fire        = req_valid_i && req_ready_o;

  assign bus_req_valid_o = ent_q[iptr_q].v && !ent_q[iptr_q].out[ihalf_q];
  assign bus_req_we_o    = ent_q[iptr_q].dump;
  assign bus_req_adr_o   = ent_q[iptr_q].adr + {{($bits(address_t)-6){1'b0}}, ihalf_q, 5'd0};
  assign bus_req_dat_o   = ihalf_q ? dat_q[iptr_q][511:256] : dat_q[iptr_q][255:0];
  assign bus_req_sel_o   = '1;
  assign bus_req_tid_o   = {iptr_q, ihalf_q};
  assign bus_fire        = bus_req_valid_o && bus_req_ready_i;

  assign ridx            = bus_resp_tid_i[TIDW-1:1];
  assign rhalf           = bus_resp_tid_i[0];
  assign resp_match      = ent_q[ridx].v && ent_q[ridx].out[rhalf] && !ent_q[ridx].done[rhalf];

  assign cmp_valid_o     = ent_q[head_q].v && (&ent_q[head_q].done)
                           && (!ent_q[head_q].load || (&ent_q[head_q].loaded));
  assign cmp_is_load_o   = ent_q[head_q].load;
  assign cmp_wa_o        = ent_q[head_q].wa;
  assign cmp_err_o       = ent_q[head_q].err;
  assign cmp_adr_o       = ent_q[head_q].adr;
  assign cmp_dat_o       = dat_q[head_q];
  assign cmp_rndx_o      = ent_q[head_q].rndx;
  assign cmp_fire        = cmp_valid_o && cmp_ready_i;

  assign stray_o         = stray_q;

  // Allocation, issue, response and completion touch disjoint fields/entries.
  always_comb begin
    ent_d   = ent_q;
    dat_d   = dat_q;
    head_d  = head_q;
    tail_d  = tail_q;
    iptr_d  = iptr_q;
    ihalf_d = ihalf_q;
    stray_d = 1'b0;

    if (req_fire) begin
      ent_d[tail_q] = '{v: 1'b1, out: '0, done: '0, loaded: '0, err: 1'b0,
                        load: req_load_i, dump: req_dump_i, wa: req_wa_i,
                        adr: line_adr(req_adr_i), rndx: req_rndx_i};
      dat_d[tail_q] = req_dat_i;
      tail_d        = tail_q + ptr_t'(1);
    end

    if (bus_fire) begin
      ent_d[iptr_q].out[ihalf_q] = 1'b1;
      ihalf_d = !ihalf_q;
      if (ihalf_q)
        iptr_d = iptr_q + ptr_t'(1);
    end

    if (bus_resp_valid_i) begin
      if (resp_match) begin
        ent_d[ridx].done[rhalf] = 1'b1;
        ent_d[ridx].err         = ent_d[ridx].err | bus_resp_err_i;
        if (ent_q[ridx].load) begin
          ent_d[ridx].loaded[rhalf] = 1'b1;
          if (rhalf)
            dat_d[ridx][511:256] = bus_resp_dat_i;
          else
            dat_d[ridx][255:0]   = bus_resp_dat_i;
        end
      end else begin
        stray_d = 1'b1;
      end
    end

    if (cmp_fire) begin
      ent_d[head_q].v = 1'b0;
      head_d          = head_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NENTRIES; i++)
        ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      iptr_q  <= '0;
      ihalf_q <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      iptr_q  <= iptr_d;
      ihalf_q <= ihalf_d;
      stray_q <= stray_d;
    end
  end

  // Line data needs no reset; it is only observed through valid entries.
  always_ff @(posedge clk_i) begin
    dat_q <= dat_d;
  end

endmodule

// File: tb/tb_dcache_line_xfer_queue.sv
// Scoreboard bench: stimulus pushes expected bus/completion records, monitors pop and compare.
module tb_dcache_line_xfer_queue;
  import cache_pkg::*;

  localparam int NENTRIES = 4;
  localparam int TIDW     = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_valid_i, req_ready_o, req_load_i, req_dump_i, req_wa_i;
  address_t        req_adr_i;
  logic [511:0]    req_dat_i;
  rob_ndx_t        req_rndx_i;
  logic            bus_req_valid_o, bus_req_ready_i, bus_req_we_o;
  address_t        bus_req_adr_o;
  logic [255:0]    bus_req_dat_o;
  logic [31:0]     bus_req_sel_o;
  logic [TIDW-1:0] bus_req_tid_o;
  logic            bus_resp_valid_i;
  logic [TIDW-1:0] bus_resp_tid_i;
  logic [255:0]    bus_resp_dat_i;
  logic            bus_resp_err_i;
  logic            cmp_valid_o, cmp_ready_i, cmp_is_load_o, cmp_wa_o, cmp_err_o;
  address_t        cmp_adr_o;
  logic [511:0]    cmp_dat_o;
  rob_ndx_t        cmp_rndx_o;
  logic            stray_o;

  always #5 clk_i = ~clk_i;

  dcache_line_xfer_queue #(.NENTRIES(NENTRIES), .TIDW(TIDW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_load_i(req_load_i),
    .req_dump_i(req_dump_i), .req_wa_i(req_wa_i), .req_adr_i(req_adr_i),
    .req_dat_i(req_dat_i), .req_rndx_i(req_rndx_i),
    .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
    .bus_req_we_o(bus_req_we_o), .bus_req_adr_o(bus_req_adr_o), .bus_req_dat_o(bus_req_dat_o),
    .bus_req_sel_o(bus_req_sel_o), .bus_req_tid_o(bus_req_tid_o),
    .bus_resp_valid_i(bus_resp_valid_i), .bus_resp_tid_i(bus_resp_tid_i),
    .bus_resp_dat_i(bus_resp_dat_i), .bus_resp_err_i(bus_resp_err_i),
    .cmp_valid_o(cmp_valid_o), .cmp_ready_i(cmp_ready_i), .cmp_is_load_o(cmp_is_load_o),
    .cmp_wa_o(cmp_wa_o), .cmp_err_o(cmp_err_o), .cmp_adr_o(cmp_adr_o),
    .cmp_dat_o(cmp_dat_o), .cmp_rndx_o(cmp_rndx_o), .stray_o(stray_o)
  );

  typedef struct packed {
    logic            we;
    address_t        adr;
    logic [255:0]    dat;
    logic [TIDW-1:0] tid;
  } bus_exp_t;

  typedef struct packed {
    logic         is_load;
    logic         wa;
    logic         err;
    address_t     adr;
    logic [511:0] dat;
    rob_ndx_t     rndx;
  } cmp_exp_t;

  bus_exp_t bus_q [$];
  cmp_exp_t cmp_q [$];
  bus_exp_t be;
  cmp_exp_t ce;
  int       cmp_cyc_q [$];
  int       n_checks  = 0;
  int       n_fail    = 0;
  int       cyc       = 0;
  int       stray_cnt = 0;
  int       acc_cyc   = -1;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic logic [255:0] pat(input int tid, input int salt);
    return {8{salt[15:0], tid[15:0]}};
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Bus request monitor
  always @(negedge clk_i) begin
    if (!rst_i && bus_req_valid_o && bus_req_ready_i) begin
      if (bus_q.size() == 0) begin
        bound_fail("bus_unexpected");
      end else begin
        be = bus_q.pop_front();
        check("bus_req", 512'({bus_req_we_o, bus_req_adr_o, bus_req_dat_o, bus_req_tid_o, bus_req_sel_o}),
              512'({be.we, be.adr, be.dat, be.tid, 32'hFFFF_FFFF}));
      end
    end
  end

  // Completion monitor
  always @(negedge clk_i) begin
    if (!rst_i && cmp_valid_o && cmp_ready_i) begin
      cmp_cyc_q.push_back(cyc);
      if (cmp_q.size() == 0) begin
        bound_fail("cmp_unexpected");
      end else begin
        ce = cmp_q.pop_front();
        check("cmp_fields", 512'({cmp_is_load_o, cmp_wa_o, cmp_err_o, cmp_adr_o, cmp_rndx_o}),
              512'({ce.is_load, ce.wa, ce.err, ce.adr, ce.rndx}));
        check("cmp_dat", cmp_dat_o, ce.dat);
      end
    end
  end

  always @(negedge clk_i) begin
    if (req_valid_i && req_ready_o) acc_cyc = cyc;
    if (stray_o) stray_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_bus(input logic we, input address_t adr, input logic [255:0] dat, input int tid);
    bus_q.push_back('{we: we, adr: adr, dat: dat, tid: TIDW'(tid)});
  endtask

  task automatic push_cmp(input logic ld, input logic wa, input logic err, input address_t adr,
                          input logic [511:0] dat, input int rndx);
    cmp_q.push_back('{is_load: ld, wa: wa, err: err, adr: adr, dat: dat, rndx: rob_ndx_t'(rndx)});
  endtask

  task automatic present(input logic ld, input logic wa, input address_t adr,
                         input logic [511:0] dat, input int rndx);
    req_valid_i = 1'b1;
    req_load_i  = ld;
    req_dump_i  = !ld;
    req_wa_i    = wa;
    req_adr_i   = adr;
    req_dat_i   = dat;
    req_rndx_i  = rob_ndx_t'(rndx);
    #1;
  endtask

  task automatic send_req(input logic ld, input logic wa, input address_t adr,
                          input logic [511:0] dat, input int rndx);
    int n = 0;
    present(ld, wa, adr, dat, rndx);
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready_o) bound_fail("req_accept_timeout");
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    while (acc_cyc < 0 && n < 50) begin
      tick();
      n++;
    end
    req_valid_i = 1'b0;
    if (acc_cyc < 0) bound_fail(name);
  endtask

  task automatic resp(input int tid, input logic [255:0] dat, input logic err);
    bus_resp_valid_i = 1'b1;
    bus_resp_tid_i   = TIDW'(tid);
    bus_resp_dat_i   = dat;
    bus_resp_err_i   = err;
    tick();
    bus_resp_valid_i = 1'b0;
    bus_resp_err_i   = 1'b0;
  endtask

  task automatic wait_bus(input int left);
    int n = 0;
    while (bus_q.size() > left && n < 100) begin
      tick();
      n++;
    end
    if (bus_q.size() > left) bound_fail("bus_issue_timeout");
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((bus_q.size() != 0 || cmp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check(name, 512'(bus_q.size() + cmp_q.size()), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    logic [511:0] e;
    address_t     a;
    int           ent;
    int           t;

    rst_i = 1'b1;
    req_valid_i = 0; req_load_i = 0; req_dump_i = 0; req_wa_i = 0;
    req_adr_i = '0; req_dat_i = '0; req_rndx_i = '0;
    bus_req_ready_i = 1'b1; cmp_ready_i = 1'b1;
    bus_resp_valid_i = 0; bus_resp_tid_i = '0; bus_resp_dat_i = '0; bus_resp_err_i = 0;
    repeat (3) tick();
    rst_i = 1'b0;
    check("rst_req_ready", 512'(req_ready_o), 512'(1));
    check("rst_bus_valid", 512'(bus_req_valid_o), 512'(0));
    check("rst_cmp_valid", 512'(cmp_valid_o), 512'(0));
    check("rst_stray", 512'(stray_o), 512'(0));

    // 1: single load, in-order responses
    push_bus(0, 32'h1040, '0, 0);
    push_bus(0, 32'h1060, '0, 1);
    push_cmp(1, 1, 0, 32'h1040, {pat(1, 1), pat(0, 1)}, 3);
    send_req(1, 1, 32'h1040, '0, 3);
    check("t1_iss_h0", 512'({bus_req_valid_o, bus_req_tid_o}), 512'({1'b1, 3'd0}));
    tick();
    check("t1_iss_h1", 512'({bus_req_valid_o, bus_req_tid_o}), 512'({1'b1, 3'd1}));
    tick();
    check("t1_iss_idle", 512'(bus_req_valid_o), 512'(0));
    resp(0, pat(0, 1), 0);
    check("t1_cmp_early", 512'(cmp_valid_o), 512'(0));
    resp(1, pat(1, 1), 0);
    check("t1_cmp_lat", 512'(cmp_valid_o), 512'(1));
    wait_drain("t1_drain");

    // 2: dump, entry 1
    d = {pat(11, 2), pat(10, 2)};
    push_bus(1, 32'h2000, d[255:0], 2);
    push_bus(1, 32'h2020, d[511:256], 3);
    push_cmp(0, 0, 0, 32'h2000, d, 5);
    send_req(0, 0, 32'h2000, d, 5);
    wait_bus(0);
    resp(2, pat(99, 9), 0);
    resp(3, pat(98, 9), 0);
    wait_drain("t2_drain");

    // 3: four loads fill the queue, responses in reverse tid order
    for (int k = 0; k < 4; k++) begin
      ent = (2 + k) % 4;
      a   = 32'h4000 + 32'(k * 64);
      push_bus(0, a, '0, 2 * ent);
      push_bus(0, a + 32'h20, '0, 2 * ent + 1);
      push_cmp(1, 0, 0, a, {pat(2 * ent + 1, 3), pat(2 * ent, 3)}, 8 + k);
    end
    push_bus(0, 32'h5000, '0, 4);
    push_bus(0, 32'h5020, '0, 5);
    push_cmp(1, 1, 0, 32'h5000, {pat(5, 4), pat(4, 4)}, 12);
    for (int k = 0; k < 4; k++)
      send_req(1, 0, 32'h4000 + 32'(k * 64), '0, 8 + k);
    acc_cyc = -1;
    present(1, 1, 32'h5000, '0, 12);
    check("t3_full_ready", 512'(req_ready_o), 512'(0));
    wait_bus(2);
    cmp_cyc_q.delete();
    for (int k = 0; k < 8; k++) begin
      t = (k < 4) ? (3 - k) : (11 - k);
      resp(t, pat(t, 3), 0);
    end
    wait_accept("t3_fifth_timeout");
    if (cmp_cyc_q.size() == 0) bound_fail("t3_no_cmp");
    else check("t3_fifth_after_cmp", 512'(acc_cyc), 512'(cmp_cyc_q[0] + 1));
    wait_bus(0);
    resp(4, pat(4, 4), 0);
    resp(5, pat(5, 4), 0);
    wait_drain("t3_drain");

    // 4: same-line hazard; 0x3020 maps to line 0x3000
    push_bus(0, 32'h3000, '0, 6);
    push_bus(0, 32'h3020, '0, 7);
    push_bus(0, 32'h3000, '0, 0);
    push_bus(0, 32'h3020, '0, 1);
    push_cmp(1, 0, 0, 32'h3000, {pat(7, 5), pat(6, 5)}, 1);
    push_cmp(1, 0, 0, 32'h3000, {pat(1, 6), pat(0, 6)}, 2);
    cmp_ready_i = 1'b0;
    send_req(1, 0, 32'h3000, '0, 1);
    acc_cyc = -1;
    present(1, 0, 32'h3020, '0, 2);
    check("t4_haz_pend", 512'(req_ready_o), 512'(0));
    repeat (3) tick();
    check("t4_haz_hold", 512'(req_ready_o), 512'(0));
    resp(6, pat(6, 5), 0);
    resp(7, pat(7, 5), 0);
    check("t4_cmp_wait", 512'(cmp_valid_o), 512'(1));
    check("t4_haz_unacked", 512'(req_ready_o), 512'(0));
    cmp_cyc_q.delete();
    cmp_ready_i = 1'b1;
    wait_accept("t4_accept_timeout");
    if (cmp_cyc_q.size() == 0) bound_fail("t4_no_cmp");
    else check("t4_accept_after_cmp", 512'(acc_cyc), 512'(cmp_cyc_q[0] + 1));
    wait_bus(0);
    resp(0, pat(0, 6), 0);
    resp(1, pat(1, 6), 0);
    wait_drain("t4_drain");

    // 5: error on half 1, then a stray tag
    push_bus(0, 32'h6000, '0, 2);
    push_bus(0, 32'h6020, '0, 3);
    push_cmp(1, 0, 1, 32'h6000, {pat(3, 7), pat(2, 7)}, 7);
    send_req(1, 0, 32'h6000, '0, 7);
    wait_bus(0);
    resp(2, pat(2, 7), 0);
    resp(3, pat(3, 7), 1);
    wait_drain("t5_drain");
    resp(6, pat(6, 8), 0);
    check("t5_stray_pulse", 512'(stray_o), 512'(1));
    tick();
    check("t5_stray_clear", 512'(stray_o), 512'(0));
    check("t5_no_state_change", 512'({bus_req_valid_o, cmp_valid_o, req_ready_o}), 512'(3'b001));

    // 6: backpressure, then reset with both halves outstanding
    e = {pat(9, 7), pat(8, 7)};
    push_bus(1, 32'h7000, e[255:0], 4);
    push_bus(1, 32'h7020, e[511:256], 5);
    bus_req_ready_i = 1'b0;
    send_req(0, 0, 32'h7000, e, 9);
    for (int i = 0; i < 5; i++) begin
      check("t6_hold", 512'({bus_req_valid_o, bus_req_we_o, bus_req_adr_o, bus_req_dat_o, bus_req_tid_o}),
            512'({1'b1, 1'b1, 32'h7000, e[255:0], 3'd4}));
      tick();
    end
    bus_req_ready_i = 1'b1;
    tick();
    tick();
    bus_req_ready_i = 1'b0;
    check("t6_issued", 512'(bus_q.size()), 512'(0));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6_rst_valids", 512'({bus_req_valid_o, cmp_valid_o, stray_o}), 512'(0));
    check("t6_rst_ready", 512'(req_ready_o), 512'(1));
    resp(4, pat(4, 9), 0);
    check("t6_late_stray0", 512'(stray_o), 512'(1));
    resp(5, pat(5, 9), 0);
    check("t6_late_stray1", 512'(stray_o), 512'(1));
    tick();
    check("t6_stray_clear", 512'(stray_o), 512'(0));
    check("t6_cmp_idle", 512'(cmp_valid_o), 512'(0));

    check("stray_total", 512'(stray_cnt), 512'(3));
    check("queues_empty", 512'(bus_q.size() + cmp_q.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
